pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the 5-stage RISC-V core. Collects stall and redirect requests from EX (jump, multi-cycle hold), ID (load-use hazard), the memory bus (wait) and the external interrupt line. Drives per-stage hold and flush strobes plus the PC redirect. Also sequences interrupt entry and keeps stall and hold-timeout bookkeeping.

## Interface
Parameters:
- IRQ_VEC, 32'h0000_0100, interrupt entry address
- MAX_HOLD, 64, consecutive ex_hold_i cycles that trip timeout_o (1..255)
- CNT_W, 32, width of stall_cnt_o

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; synchronous, active-high
- jump_flag_i  in  1  EX branch/jump taken
- jump_addr_i  in  32  EX jump target
- ex_hold_i  in  1  EX multi-cycle op in progress
- load_use_i  in  1  ID: load in EX writes a source register of the ID instruction
- bus_wait_i  in  1  memory bus not ready this cycle
- irq_i  in  1  external interrupt request, level
- hold_pc_o  out  1  freeze PC
- hold_ifid_o  out  1  freeze IF/ID register
- hold_idex_o  out  1  freeze ID/EX register
- flush_ifid_o  out  1  load NOP into IF/ID
- flush_idex_o  out  1  load NOP into ID/EX
- jump_flag_o  out  1  redirect PC this cycle
- jump_addr_o  out  32  redirect target; 0 when jump_flag_o=0
- irq_ack_o  out  1  one-cycle pulse on interrupt entry
- timeout_o  out  1  sticky EX hold timeout
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o=1, saturating

## Operation
- FSM states: RUN, IRQ_REDIR.
- RUN arbitration, highest priority first. All outputs are combinational from inputs and state.
  1. bus_wait_i: set hold_pc, hold_ifid, hold_idex. No flush, no jump. EX holds jump_flag_i stable through the wait.
  2. ex_hold_i: set hold_pc, hold_ifid, hold_idex.
  3. jump_flag_i: set jump_flag_o and jump_addr_o=jump_addr_i. Set flush_ifid and flush_idex. Load-use and irq are ignored this cycle.
  4. load_use_i: set hold_pc and hold_ifid, and flush_idex (bubble).
  5. irq_i with none of the above: next state is IRQ_REDIR. No outputs this cycle.
- IRQ_REDIR:
  - bus_wait_i or ex_hold_i set: stay in IRQ_REDIR with all holds set. No ack.
  - Otherwise: jump_flag_o=1, jump_addr_o=IRQ_VEC, flush_ifid=flush_idex=1, irq_ack_o=1. Next state is RUN.
  - load_use_i and jump_flag_i are ignored in IRQ_REDIR, because the flush discards both instructions.
- The irq source must drop irq_i by the cycle after irq_ack_o. A still-asserted irq_i is taken again.
- Hold watchdog: hold_cnt (8 bit) increments each cycle ex_hold_i=1 and clears when ex_hold_i=0. When it reaches MAX_HOLD, timeout_o is set and stays set until rst. hold_cnt saturates at MAX_HOLD.
- stall_cnt_o increments on each cycle with hold_pc_o=1 and stops at all-ones.

## Timing
- Reset: state RUN; hold_cnt, stall_cnt_o and timeout_o at 0. With inputs low, all outputs are 0.
- Hold, flush and jump outputs act in the same cycle as the request. Pipeline registers act on the next edge.
- Interrupt latency: 1 cycle from irq_i sampled in RUN to redirect, plus the cycles spent in IRQ_REDIR while held.
- A jump arriving together with bus_wait_i is honoured in the first cycle after bus_wait_i drops.
- rst during IRQ_REDIR aborts entry: no irq_ack_o is issued.
- timeout_o rises on the edge where hold_cnt reaches MAX_HOLD: the MAX_HOLD-th consecutive hold cycle.

## Structure
- Package pipe_ctrl_pkg: state enum {RUN, IRQ_REDIR}, default IRQ_VEC, NOP encoding 32'h0000_0013 used by the stage registers.
- Sub-module hold_watchdog: hold_cnt, compare against MAX_HOLD, sticky timeout_o.
- Arbitration and FSM live in pipe_ctrl.

## Test plan
- Reset, then idle inputs → all outputs 0, stall_cnt_o=0.
- jump_flag_i=1, jump_addr_i=32'h80 for 1 cycle → jump_flag_o=1, jump_addr_o=32'h80, both flushes set in the same cycle. Next cycle all outputs are 0.
- load_use_i=1 for 1 cycle → hold_pc=hold_ifid=flush_idex=1, stall_cnt_o=1 next cycle.
- irq_i=1 while bus_wait_i=1 for 3 cycles → holds only, no ack. Then 1 cycle in RUN, then IRQ_REDIR with jump_addr_o=32'h100 and irq_ack_o=1.
- ex_hold_i=1 for 64 cycles with MAX_HOLD=64 → timeout_o=1 after the 64th hold cycle. It stays 1 after ex_hold_i drops and clears only on rst.
- jump_flag_i and load_use_i and irq_i together → jump only, no load-use bubble. Interrupt entry follows 2 cycles later if irq_i is held.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// pipe_ctrl_pkg : shared types and constants for the pipeline control unit
// Revision 1.0
// ==========================================================================
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN       = 1'b0,
      IRQ_REDIR = 1'b1
   } state_e;

   localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h0000_0100;
   // Encoding of addi x0,x0,0 loaded into stage registers on a flush.
   localparam logic [31:0] NOP_INSN        = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hold_watchdog.sv
`default_nettype none
// ==========================================================================
// hold_watchdog : counts consecutive EX hold cycles, sticky timeout flag
// Revision 1.0
// ==========================================================================
module hold_watchdog #(
   parameter int MAX_HOLD = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic ex_hold_i,
   output logic timeout_o
);

   localparam logic [7:0] C_MAX = 8'(MAX_HOLD);

   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       timeout_q, timeout_d;

   always_comb begin
      hold_cnt_d = 8'd0;
      if (ex_hold_i) begin
         hold_cnt_d = (hold_cnt_q == C_MAX) ? hold_cnt_q : hold_cnt_q + 8'd1;
      end
      // Sets on the very edge the counter lands on the limit.
      timeout_d = timeout_q | (hold_cnt_d == C_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ==========================================================================
// pipe_ctrl : 5-stage pipeline hold/flush/redirect arbitration, irq entry
// Revision 1.0
// ==========================================================================
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEFAULT,
   parameter int          MAX_HOLD = 64,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jump_flag_i,
   input  logic [31:0]      jump_addr_i,
   input  logic             ex_hold_i,
   input  logic             load_use_i,
   input  logic             bus_wait_i,
   input  logic             irq_i,
   output logic             hold_pc_o,
   output logic             hold_ifid_o,
   output logic             hold_idex_o,
   output logic             flush_ifid_o,
   output logic             flush_idex_o,
   output logic             jump_flag_o,
   output logic [31:0]      jump_addr_o,
   output logic             irq_ack_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_pc_o    = 1'b0;
      hold_ifid_o  = 1'b0;
      hold_idex_o  = 1'b0;
      flush_ifid_o = 1'b0;
      flush_idex_o = 1'b0;
      jump_flag_o  = 1'b0;
      jump_addr_o  = 32'd0;
      irq_ack_o    = 1'b0;

      // Outputs are quiet in reset so an aborted irq entry never acks.
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (bus_wait_i || ex_hold_i) begin
                  hold_pc_o   = 1'b1;
                  hold_ifid_o = 1'b1;
                  hold_idex_o = 1'b1;
               end else if (jump_flag_i) begin
                  jump_flag_o  = 1'b1;
                  jump_addr_o  = jump_addr_i;
                  flush_ifid_o = 1'b1;
                  flush_idex_o = 1'b1;
               end else if (load_use_i) begin
                  hold_pc_o    = 1'b1;
                  hold_ifid_o  = 1'b1;
                  flush_idex_o = 1'b1;
               end else if (irq_i) begin
                  state_d = IRQ_REDIR;
               end
            end
            IRQ_REDIR: begin
               if (bus_wait_i || ex_hold_i) begin
                  hold_pc_o   = 1'b1;
                  hold_ifid_o = 1'b1;
                  hold_idex_o = 1'b1;
               end else begin
                  jump_flag_o  = 1'b1;
                  jump_addr_o  = IRQ_VEC;
                  flush_ifid_o = 1'b1;
                  flush_idex_o = 1'b1;
                  irq_ack_o    = 1'b1;
                  state_d      = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end

      stall_cnt_d = stall_cnt_q;
      if (hold_pc_o && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

   hold_watchdog #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_watchdog (
      .clk       (clk),
      .rst       (rst),
      .ex_hold_i (ex_hold_i),
      .timeout_o (timeout_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Revision 1.0
// ==========================================================================
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        ex_hold_i;
   logic        load_use_i;
   logic        bus_wait_i;
   logic        irq_i;
   logic        hold_pc_o, hold_ifid_o, hold_idex_o;
   logic        flush_ifid_o, flush_idex_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        irq_ack_o;
   logic        timeout_o;
   logic [31:0] stall_cnt_o;

   int checks = 0;
   int passes = 0;

   // {hold_pc, hold_ifid, hold_idex, flush_ifid, flush_idex, jump_flag, irq_ack}
   logic [6:0] ctl;
   assign ctl = {hold_pc_o, hold_ifid_o, hold_idex_o, flush_ifid_o,
                 flush_idex_o, jump_flag_o, irq_ack_o};

   localparam logic [6:0] C_IDLE  = 7'b000_0000;
   localparam logic [6:0] C_HOLD  = 7'b111_0000;
   localparam logic [6:0] C_JUMP  = 7'b000_1110;
   localparam logic [6:0] C_LU    = 7'b110_0100;
   localparam logic [6:0] C_IRQ   = 7'b000_1111;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .IRQ_VEC  (32'h0000_0100),
      .MAX_HOLD (64),
      .CNT_W    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .ex_hold_i    (ex_hold_i),
      .load_use_i   (load_use_i),
      .bus_wait_i   (bus_wait_i),
      .irq_i        (irq_i),
      .hold_pc_o    (hold_pc_o),
      .hold_ifid_o  (hold_ifid_o),
      .hold_idex_o  (hold_idex_o),
      .flush_ifid_o (flush_ifid_o),
      .flush_idex_o (flush_idex_o),
      .jump_flag_o  (jump_flag_o),
      .jump_addr_o  (jump_addr_o),
      .irq_ack_o    (irq_ack_o),
      .timeout_o    (timeout_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   task automatic drive(input logic jf, input logic [31:0] ja, input logic eh,
                        input logic lu, input logic bw, input logic irq);
      jump_flag_i = jf;
      jump_addr_i = ja;
      ex_hold_i   = eh;
      load_use_i  = lu;
      bus_wait_i  = bw;
      irq_i       = irq;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE) $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE);
      else passes++;
      checks++;
      if (jump_addr_o !== 32'd0) $display("FAIL reset_addr got %h want 0", jump_addr_o);
      else passes++;
      checks++;
      if (timeout_o !== 1'b0 || stall_cnt_o !== 32'd0)
         $display("FAIL reset_cnt got to=%b stall=%0d want 0/0", timeout_o, stall_cnt_o);
      else passes++;
      tick();
   endtask

   task automatic test_jump();
      drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_JUMP || jump_addr_o !== 32'h80)
         $display("FAIL jump got ctl=%b addr=%h want %b/00000080", ctl, jump_addr_o, C_JUMP);
      else passes++;
      tick();
      drive(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_IDLE || jump_addr_o !== 32'd0)
         $display("FAIL jump_after got ctl=%b addr=%h want %b/0", ctl, jump_addr_o, C_IDLE);
      else passes++;
      tick();
   endtask

   task automatic test_load_use();
      drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_LU) $display("FAIL load_use got %b want %b", ctl, C_LU);
      else passes++;
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt_o !== 32'd1 || ctl !== C_IDLE)
         $display("FAIL load_use_after got stall=%0d ctl=%b want 1/%b", stall_cnt_o, ctl, C_IDLE);
      else passes++;
      tick();
   endtask

   task automatic test_irq_bus_wait();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
         checks++;
         if (ctl !== C_HOLD) $display("FAIL irq_bw_hold[%0d] got %b want %b", i, ctl, C_HOLD);
         else passes++;
         tick();
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (ctl !== C_IDLE) $display("FAIL irq_run got %b want %b", ctl, C_IDLE);
      else passes++;
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_IRQ || jump_addr_o !== 32'h100)
         $display("FAIL irq_entry got ctl=%b addr=%h want %b/00000100", ctl, jump_addr_o, C_IRQ);
      else passes++;
      tick();
      checks++;
      if (ctl !== C_IDLE || stall_cnt_o !== 32'd4)
         $display("FAIL irq_done got ctl=%b stall=%0d want %b/4", ctl, stall_cnt_o, C_IDLE);
      else passes++;
   endtask

   task automatic test_jump_priority();
      drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (ctl !== C_JUMP || jump_addr_o !== 32'h200)
         $display("FAIL jprio got ctl=%b addr=%h want %b/00000200", ctl, jump_addr_o, C_JUMP);
      else passes++;
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (ctl !== C_IDLE) $display("FAIL jprio_run got %b want %b", ctl, C_IDLE);
      else passes++;
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_IRQ || jump_addr_o !== 32'h100)
         $display("FAIL jprio_irq got ctl=%b addr=%h want %b/00000100", ctl, jump_addr_o, C_IRQ);
      else passes++;
      tick();
   endtask

   task automatic test_jump_bus_wait();
      drive(1'b1, 32'h340, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (ctl !== C_HOLD || jump_addr_o !== 32'd0)
         $display("FAIL jbw_wait got ctl=%b addr=%h want %b/0", ctl, jump_addr_o, C_HOLD);
      else passes++;
      tick();
      drive(1'b1, 32'h340, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_JUMP || jump_addr_o !== 32'h340)
         $display("FAIL jbw_go got ctl=%b addr=%h want %b/00000340", ctl, jump_addr_o, C_JUMP);
      else passes++;
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt_o !== 32'd5) $display("FAIL jbw_stall got %0d want 5", stall_cnt_o);
      else passes++;
   endtask

   task automatic test_irq_redir_hold();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0);
         checks++;
         if (ctl !== C_HOLD) $display("FAIL redir_hold[%0d] got %b want %b", i, ctl, C_HOLD);
         else passes++;
         tick();
      end
      drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_IRQ || jump_addr_o !== 32'h100)
         $display("FAIL redir_go got ctl=%b addr=%h want %b/00000100", ctl, jump_addr_o, C_IRQ);
      else passes++;
      tick();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt_o !== 32'd7 || ctl !== C_IDLE)
         $display("FAIL redir_after got stall=%0d ctl=%b want 7/%b", stall_cnt_o, ctl, C_IDLE);
      else passes++;
   endtask

   task automatic test_timeout();
      // Two 40-cycle runs split by an idle cycle must not trip the watchdog.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 40; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
         end
         drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      checks++;
      if (timeout_o !== 1'b0) $display("FAIL to_split got %b want 0", timeout_o);
      else passes++;
      for (int i = 0; i < 64; i++) begin
         drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 63) begin
            checks++;
            if (timeout_o !== 1'b0 || ctl !== C_HOLD)
               $display("FAIL to_63 got to=%b ctl=%b want 0/%b", timeout_o, ctl, C_HOLD);
            else passes++;
         end
         tick();
      end
      checks++;
      if (timeout_o !== 1'b1) $display("FAIL to_64 got %b want 1", timeout_o);
      else passes++;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      checks++;
      if (timeout_o !== 1'b1 || stall_cnt_o !== 32'd151)
         $display("FAIL to_sticky got to=%b stall=%0d want 1/151", timeout_o, stall_cnt_o);
      else passes++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (timeout_o !== 1'b0 || stall_cnt_o !== 32'd0)
         $display("FAIL to_rst got to=%b stall=%0d want 0/0", timeout_o, stall_cnt_o);
      else passes++;
      tick();
   endtask

   task automatic test_rst_abort();
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (irq_ack_o !== 1'b0) $display("FAIL abort_rst got ack=%b want 0", irq_ack_o);
      else passes++;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (ctl !== C_IDLE || jump_addr_o !== 32'd0)
         $display("FAIL abort_after got ctl=%b addr=%h want %b/0", ctl, jump_addr_o, C_IDLE);
      else passes++;
      tick();
   endtask

   initial begin
      test_reset();
      test_jump();
      test_load_use();
      test_irq_bus_wait();
      test_jump_priority();
      test_jump_bus_wait();
      test_irq_redir_hold();
      test_timeout();
      test_rst_abort();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
